// File: rtl/somador_serial_ctrl_if.sv
// rtl/somador_serial_ctrl_if.sv - request/result bundle for the bit-serial adder
// Optional SOMADOR_SUB_EN adds the sub request bit.
interface somador_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SOMADOR_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] soma;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef SOMADOR_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, soma, cout, ovf
  );

  modport slave (
`ifdef SOMADOR_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, soma, cout, ovf
  );
endinterface

// File: rtl/somador_serial_ctrl.sv
// rtl/somador_serial_ctrl.sv - bit-serial WIDTH-bit adder around one full-adder cell
// Define SOMADOR_SUB_EN to add subtraction (a - b) selected by bus.sub.
module somador_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  somador_serial_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_bit;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign s_bit    = op_a[0] ^ op_b[0] ^ carry;
  assign c_bit    = (op_a[0] & op_b[0]) | ((op_a[0] ^ op_b[0]) & carry);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef SOMADOR_SUB_EN
  // a - b computed as a + ~b + 1
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  // Sum bits enter op_a's vacated MSB, so op_a doubles as the result shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.soma <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_a     <= bus.a;
            op_b     <= b_load;
            carry    <= c_load;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          op_a  <= {s_bit, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          carry <= c_bit;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            // carry here is the carry into the MSB
            bus.soma <= {s_bit, op_a[WIDTH-1:1]};
            bus.cout <= c_bit;
            bus.ovf  <= carry ^ c_bit;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/somador_serial_ctrl.md
Name: somador_serial_ctrl

Overview:
- Bit-serial N-bit adder controller.
- Latches two WIDTH-bit operands on a start request and sequences one internal 1-bit full adder, LSB first, one bit per clock.
- Carry is held in a register between bits; sum bits are shifted into a result register.
- Gives small-area multi-bit addition to workshop designs that only own a single full-adder cell; start/busy/done handshake toward the requesting logic.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
CNT_W, $clog2(WIDTH)+1, bit counter width (derived, not overridden)

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse, result valid
soma  output  WIDTH  sum result, held until next accepted start
cout  output  1  final carry-out, held with soma
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB), held with soma

Behaviour:
- Reset (asynchronous, active-high; applies at any time):
  - FSM goes to IDLE; counter, operand regs and carry reg cleared.
  - busy=0, done=0, soma=0, cout=0, ovf=0.
  - Reset mid-operation aborts; no done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - start=1 at a rising edge: latch a->opA, b->opB, cin->carry reg; counter=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), each edge:
  - s_bit = opA[0]^opB[0]^carry.
  - c_bit = (opA[0]&opB[0]) | ((opA[0]^opB[0])&carry).
  - Result reg shifts right; s_bit enters the MSB.
  - opA and opB shift right; carry <= c_bit; counter++.
  - On the edge where counter==WIDTH-1, record c_msb_in = carry (carry into MSB), then go to DONE.
- DONE:
  - Lasts one cycle; done=1, busy=0.
  - soma, cout (final carry), ovf = c_msb_in ^ cout are already valid in this cycle.
  - Next state is IDLE unconditionally; start is ignored in DONE.
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH (WIDTH+1 cycles from acceptance to done).
- Throughput: one operation per WIDTH+2 cycles at minimum.
- start while busy or done: ignored, no queuing; a, b, cin may change freely after acceptance.
- soma, cout and ovf are updated only by the DONE transition. They keep the last result through IDLE and through the next SHIFT phase, until the next DONE.
- All arithmetic is modulo 2^WIDTH; no saturation.

Optional Feature:
SOMADOR_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1: opB latched as ~b, carry reg loaded with 1 (cin ignored); result = a - b.
  - cout=1 means no borrow; ovf is signed overflow of the subtraction.
- Undefined:
  - Port sub absent; addition only, exactly as above.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulse -> busy for 8 cycles, done 9 cycles after acceptance, soma=8'h10, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 -> soma=8'h00, cout=1, ovf=0; a=8'hFF, b=8'h00, cin=1 -> soma=8'h00, cout=1.
- a=8'h7F, b=8'h01, cin=0 -> soma=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> soma=8'h00, cout=1, ovf=1.
- Accept a=8'h12, b=8'h34; pulse start with a=8'hFF, b=8'hFF during SHIFT -> ignored, soma=8'h46 after done, exactly one done pulse.
- Assert rst at 4th SHIFT cycle -> busy, done, soma immediately 0, FSM in IDLE; a new start then yields the correct sum.
- SOMADOR_SUB_EN: a=8'h05, b=8'h07, sub=1 -> soma=8'hFE, cout=0, ovf=0; a=8'h80, b=8'h01, sub=1 -> soma=8'h7F, cout=1, ovf=1.
